// File: rtl/ccff_pkg.sv
// Shared types and constants for the CLB configuration-chain loader.
// Holds the FSM state encoding, CRC-16-CCITT constants and the word-count helper.
package ccff_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } ccff_state_e;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_SEED = 16'hFFFF;

   // Words required to cover the chain; the last word may be only partly used.
   function automatic int words_needed(input int chain_len, input int word_w);
      return (chain_len + word_w - 1) / word_w;
   endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Shift register plus holding register that turns bitstream words into a
// gap-free LSB-first bit stream; the holding register refills the shifter on its last bit.
module ccff_word_serializer #(
   parameter int WORD_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              load_en_i,
   input  logic              accept_en_i,
   input  logic              shift_allow_i,
   input  logic [WORD_W-1:0] data_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic              accept_o,
   output logic              shift_o,
   output logic              bit_o
);

   localparam int SC_W = $clog2(WORD_W + 1);
   localparam logic [SC_W-1:0] FULL_CNT = SC_W'(WORD_W);
   localparam logic [SC_W-1:0] ONE_CNT  = SC_W'(1);

   logic [WORD_W-1:0] sr_q, sr_d, hr_q, hr_d;
   logic [SC_W-1:0]   sr_cnt_q, sr_cnt_d;
   logic              hr_valid_q, hr_valid_d;
   logic              move;

   always_comb begin
      ready_o  = load_en_i && accept_en_i && !hr_valid_q;
      accept_o = ready_o && valid_i;
      shift_o  = shift_allow_i && (sr_cnt_q != '0);
      bit_o    = sr_q[0];
      // Refill on an empty shifter, or in the same cycle its last bit leaves.
      move     = load_en_i && hr_valid_q &&
                 ((sr_cnt_q == '0) || ((sr_cnt_q == ONE_CNT) && shift_o));

      sr_d       = sr_q;
      sr_cnt_d   = sr_cnt_q;
      hr_d       = hr_q;
      hr_valid_d = hr_valid_q;
      if (move) begin
         sr_d     = hr_q;
         sr_cnt_d = FULL_CNT;
      end else if (shift_o) begin
         sr_d     = {1'b0, sr_q[WORD_W-1:1]};
         sr_cnt_d = sr_cnt_q - 1'b1;
      end
      if (accept_o) begin
         hr_d       = data_i;
         hr_valid_d = 1'b1;
      end else if (move) begin
         hr_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         sr_q       <= '0;
         sr_cnt_q   <= '0;
         hr_q       <= '0;
         hr_valid_q <= 1'b0;
      end else begin
         sr_q       <= sr_d;
         sr_cnt_q   <= sr_cnt_d;
         hr_q       <= hr_d;
         hr_valid_q <= hr_valid_d;
      end
   end

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration sequencer for one CLB tile's CCFF chain: loads CHAIN_LEN bits and
// then releases fabric reset. Define CCFF_READBACK_EN to add a CRC-16 readback of ccff_tail.
module ccff_chain_loader
   import ccff_pkg::*;
#(
   parameter int  CHAIN_LEN = 1024,
   parameter int  WORD_W    = 8,
   localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              prog_clk,
   input  logic              prog_reset,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              shift_en,
   output logic              fabric_reset,
   output logic              busy,
   output logic              done,
`ifdef CCFF_READBACK_EN
   output logic [15:0]       readback_crc,
`endif
   output logic [CNT_W-1:0]  bit_count
);

   localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(CHAIN_LEN - 1);
   localparam logic [CNT_W-1:0] WORD_LIMIT = CNT_W'(words_needed(CHAIN_LEN, WORD_W));

   ccff_state_e      state_q, state_d;
   logic [CNT_W-1:0] bit_count_q, bit_count_d;
   logic [CNT_W-1:0] words_q, words_d;
   logic             head_q, head_d;
   logic             start_ok, flush, in_load, shift_allow, words_open;
   logic             shift, sr_bit, accept;

   always_comb begin
      start_ok    = start && !abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
      flush       = abort || start_ok;
      in_load     = (state_q == ST_LOAD);
      shift_allow = in_load && (bit_count_q <= LAST_BIT);
      words_open  = (words_q != WORD_LIMIT);
   end

   ccff_word_serializer #(.WORD_W(WORD_W)) u_ser (
      .clk_i         (prog_clk),
      .rst_i         (prog_reset),
      .flush_i       (flush),
      .load_en_i     (in_load),
      .accept_en_i   (words_open),
      .shift_allow_i (shift_allow),
      .data_i        (cfg_data),
      .valid_i       (cfg_valid),
      .ready_o       (cfg_ready),
      .accept_o      (accept),
      .shift_o       (shift),
      .bit_o         (sr_bit)
   );

   // Abort has priority over start in every state; start is ignored while busy.
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_LOAD;
            ST_LOAD:          if (shift && (bit_count_q == LAST_BIT)) state_d = ST_DRAIN;
            ST_DRAIN:         state_d = ST_DONE;
            default:          state_d = ST_IDLE;
         endcase
      end

      bit_count_d = bit_count_q;
      if (start_ok)   bit_count_d = '0;
      else if (shift) bit_count_d = bit_count_q + 1'b1;

      words_d = words_q;
      if (flush)       words_d = '0;
      else if (accept) words_d = words_q + 1'b1;

      head_d = shift ? sr_bit : head_q;

      shift_en     = shift;
      ccff_head    = head_d;
      fabric_reset = (state_q != ST_DONE);
      busy         = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
      done         = (state_q == ST_DONE);
      bit_count    = bit_count_q;
   end

   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         state_q     <= ST_IDLE;
         bit_count_q <= '0;
         words_q     <= '0;
         head_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_count_q <= bit_count_d;
         words_q     <= words_d;
         head_q      <= head_d;
      end
   end

`ifdef CCFF_READBACK_EN
   logic [15:0] crc_q, crc_d;
   logic        crc_fb;

   // Tail bits are the previous chain contents, so this signs the prior configuration.
   always_comb begin
      crc_fb = crc_q[15] ^ ccff_tail;
      crc_d  = crc_q;
      if (start_ok)   crc_d = CRC16_SEED;
      else if (shift) crc_d = {crc_q[14:0], 1'b0} ^ (crc_fb ? CRC16_POLY : 16'h0000);
   end

   always_ff @(posedge prog_clk) begin
      if (prog_reset) crc_q <= CRC16_SEED;
      else            crc_q <= crc_d;
   end

   assign readback_crc = crc_q;
`else
   logic unused_tail;
   assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: a 16-bit chain instance and a 13-bit
// partial-word instance, with a behavioural chain model feeding ccff_tail.
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: CHAIN_LEN=16
  logic       start_a, abort_a, cfg_valid_a, cfg_ready_a, ccff_head_a, ccff_tail_a;
  logic       shift_en_a, fabric_reset_a, busy_a, done_a;
  logic [7:0] cfg_data_a;
  logic [4:0] bit_count_a;

  // Instance B: CHAIN_LEN=13
  logic       start_b, abort_b, cfg_valid_b, cfg_ready_b, ccff_head_b, ccff_tail_b;
  logic       shift_en_b, fabric_reset_b, busy_b, done_b;
  logic [7:0] cfg_data_b;
  logic [3:0] bit_count_b;

`ifdef CCFF_READBACK_EN
  logic [15:0] readback_crc_a, readback_crc_b;
`endif

  ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) u_dut_a (
    .prog_clk     (clk),
    .prog_reset   (rst),
    .start        (start_a),
    .abort        (abort_a),
    .cfg_data     (cfg_data_a),
    .cfg_valid    (cfg_valid_a),
    .cfg_ready    (cfg_ready_a),
    .ccff_head    (ccff_head_a),
    .ccff_tail    (ccff_tail_a),
    .shift_en     (shift_en_a),
    .fabric_reset (fabric_reset_a),
    .busy         (busy_a),
    .done         (done_a),
`ifdef CCFF_READBACK_EN
    .readback_crc (readback_crc_a),
`endif
    .bit_count    (bit_count_a)
  );

  ccff_chain_loader #(.CHAIN_LEN(13), .WORD_W(8)) u_dut_b (
    .prog_clk     (clk),
    .prog_reset   (rst),
    .start        (start_b),
    .abort        (abort_b),
    .cfg_data     (cfg_data_b),
    .cfg_valid    (cfg_valid_b),
    .cfg_ready    (cfg_ready_b),
    .ccff_head    (ccff_head_b),
    .ccff_tail    (ccff_tail_b),
    .shift_en     (shift_en_b),
    .fabric_reset (fabric_reset_b),
    .busy         (busy_b),
    .done         (done_b),
`ifdef CCFF_READBACK_EN
    .readback_crc (readback_crc_b),
`endif
    .bit_count    (bit_count_b)
  );

  // 16-bit chain model behind instance A, preloadable with a known image
  logic [15:0] chain_q;
  logic        preload;
  always @(posedge clk) begin
    if (preload)         chain_q <= 16'h1234;
    else if (shift_en_a) chain_q <= {ccff_head_a, chain_q[15:1]};
  end
  assign ccff_tail_a = chain_q[0];
  assign ccff_tail_b = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] crc_of(input logic [15:0] bits);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      fb = c[15] ^ bits[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // Results of the most recent load on instance A
  int          n_shift, stall, drain, cyc;
  logic [15:0] head_bits;
  logic        stall_head;

  // Drives a two-word load on A. gap: idle cycles of cfg_valid after the first
  // word has fully shifted (0 = stream continuously). abort_at: return early once
  // that many bits shifted. restart_at: pulse start while busy at that bit count.
  task automatic load_a(input logic [7:0] w0, input logic [7:0] w1, input int gap,
                        input int abort_at, input int restart_at);
    int   idx, gap_ctr;
    logic hs, restarted;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("load_start_bit_count", bit_count_a, 0);
    chk("load_start_busy", busy_a, 1);
    chk("load_start_fabric_reset", fabric_reset_a, 1);
    idx = 0; gap_ctr = 0; restarted = 1'b0;
    n_shift = 0; stall = 0; drain = 0; cyc = 0; head_bits = '0; stall_head = 1'b0;
    cfg_data_a  = w0;
    cfg_valid_a = 1'b1;
    while (!done_a && cyc < 200) begin
      if (abort_at > 0 && n_shift == abort_at) break;
      hs = cfg_valid_a && cfg_ready_a;
      if (shift_en_a) begin
        if (n_shift < 16) head_bits[n_shift] = ccff_head_a;
        n_shift++;
      end else if (n_shift > 0 && n_shift < 16) begin
        stall++;
        stall_head = ccff_head_a;
      end else if (n_shift == 16 && busy_a) begin
        drain++;
      end
      if (restart_at > 0 && n_shift == restart_at && !restarted) begin
        start_a   = 1'b1;
        restarted = 1'b1;
        tick();
        start_a = 1'b0;
        chk("start_in_load_bit_count", bit_count_a, n_shift);
        chk("start_in_load_busy", busy_a, 1);
      end else begin
        tick();
      end
      cyc++;
      if (hs) begin
        idx++;
        if (idx == 1) begin
          cfg_data_a  = w1;
          cfg_valid_a = (gap == 0);
        end else begin
          cfg_valid_a = 1'b0;
        end
      end
      if (idx == 1 && !cfg_valid_a && n_shift >= 8) begin
        if (gap_ctr == gap) cfg_valid_a = 1'b1;
        else                gap_ctr++;
      end
    end
    chk("load_within_budget", (cyc < 200), 1);
  endtask

  initial begin
    int n_b, acc_b, late_b, drain_b, cyc_b;
    rst = 1'b1; preload = 1'b1;
    start_a = 0; abort_a = 0; cfg_valid_a = 0; cfg_data_a = '0;
    start_b = 0; abort_b = 0; cfg_valid_b = 0; cfg_data_b = '0;
    repeat (3) tick();
    rst = 1'b0; preload = 1'b0;

    // Reset state
    chk("rst_cfg_ready", cfg_ready_a, 0);
    chk("rst_ccff_head", ccff_head_a, 0);
    chk("rst_shift_en", shift_en_a, 0);
    chk("rst_fabric_reset", fabric_reset_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_bit_count", bit_count_a, 0);
    chk("rst_b_fabric_reset", fabric_reset_b, 1);
`ifdef CCFF_READBACK_EN
    chk("rst_crc", readback_crc_a, 16'hFFFF);
`endif

    // Continuous load: 0xA5 then 0x3C, 16 back-to-back shifts
    load_a(8'hA5, 8'h3C, 0, 0, 0);
    chk("cont_shifts", n_shift, 16);
    chk("cont_stalls", stall, 0);
    chk("cont_head_seq", head_bits, 16'h3CA5);
    chk("cont_drain_cycles", drain, 1);
    chk("cont_done", done_a, 1);
    chk("cont_fabric_reset", fabric_reset_a, 0);
    chk("cont_bit_count", bit_count_a, 16);
    chk("cont_busy", busy_a, 0);
    chk("cont_cfg_ready", cfg_ready_a, 0);
`ifdef CCFF_READBACK_EN
    chk("readback_crc", readback_crc_a, crc_of(16'h1234));
    repeat (3) tick();
    chk("readback_crc_stable", readback_crc_a, crc_of(16'h1234));
`endif
    repeat (2) tick();
    chk("done_hold", done_a, 1);

    // Stalled load: 5 idle cycles of cfg_valid give a 7-cycle shift gap
    load_a(8'hA5, 8'h3C, 5, 0, 0);
    chk("stall_shifts", n_shift, 16);
    chk("stall_cycles", stall, 7);
    chk("stall_head_seq", head_bits, 16'h3CA5);
    chk("stall_head_hold", stall_head, 1);
    chk("stall_bit_count", bit_count_a, 16);
    chk("stall_done", done_a, 1);

    // start and abort together in DONE -> IDLE
    start_a = 1'b1; abort_a = 1'b1;
    tick();
    start_a = 1'b0; abort_a = 1'b0;
    chk("collide_done", done_a, 0);
    chk("collide_busy", busy_a, 0);
    chk("collide_fabric_reset", fabric_reset_a, 1);

    // Abort after 7 shifts
    load_a(8'hA5, 8'h3C, 0, 7, 0);
    chk("abort_reached_7", n_shift, 7);
    abort_a = 1'b1; cfg_valid_a = 1'b0;
    tick();
    abort_a = 1'b0;
    chk("abort_shift_en", shift_en_a, 0);
    chk("abort_fabric_reset", fabric_reset_a, 1);
    chk("abort_done", done_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_cfg_ready", cfg_ready_a, 0);
    repeat (2) tick();
    chk("abort_stays_idle", busy_a, 0);

    // Full reload after abort, with a start pulse mid-load that must be ignored
    load_a(8'h5A, 8'hC3, 0, 0, 4);
    chk("reload_shifts", n_shift, 16);
    chk("reload_head_seq", head_bits, 16'hC35A);
    chk("reload_bit_count", bit_count_a, 16);
    chk("reload_done", done_a, 1);

    // Partial final word on the 13-bit instance
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    cfg_data_b = 8'hFF; cfg_valid_b = 1'b1;
    n_b = 0; acc_b = 0; late_b = 0; drain_b = 0; cyc_b = 0;
    while (!done_b && cyc_b < 200) begin
      if (cfg_ready_b && acc_b >= 2) late_b++;
      if (cfg_valid_b && cfg_ready_b) acc_b++;
      if (shift_en_b) n_b++;
      else if (n_b == 13 && busy_b) drain_b++;
      tick();
      cyc_b++;
    end
    cfg_valid_b = 1'b0;
    chk("part_within_budget", (cyc_b < 200), 1);
    chk("part_shifts", n_b, 13);
    chk("part_words", acc_b, 2);
    chk("part_late_ready", late_b, 0);
    chk("part_drain_cycles", drain_b, 1);
    chk("part_bit_count", bit_count_b, 13);
    chk("part_done", done_b, 1);
    chk("part_fabric_reset", fabric_reset_b, 0);

    // prog_reset in the middle of a load
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    cfg_data_a = 8'h0F; cfg_valid_a = 1'b1;
    repeat (5) tick();
    chk("midrst_shifting", bit_count_a, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0; cfg_valid_a = 1'b0;
    chk("midrst_bit_count", bit_count_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_fabric_reset", fabric_reset_a, 1);
    chk("midrst_shift_en", shift_en_a, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
